wresp_outstd_mngr: RTL and testbench

- Parametrised successor to the single-outstanding write-response manager.
- Tracks up to DEPTH outstanding write transactions by ID.
- Accepts B-channel responses in any order across IDs and pulses a completion per matched response.
- Sits between the write-data channel manager (which reports finish_wd/finish_id) and the bus B channel; errors are sticky with a recoverable clear.

---
 rtl/wresp_outstd_mngr_pkg.sv | 28 ++
 rtl/wresp_outstd_mngr_if.sv | 32 +++
 rtl/wresp_id_table.sv | 65 ++++++
 rtl/wresp_outstd_mngr.sv | 117 +++++++++++
 tb/tb_wresp_outstd_mngr.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wresp_outstd_mngr_pkg.sv
// Shared types for the multi-outstanding write-response manager:
// FSM state encoding, error codes and small sizing/counting helpers.
package wresp_outstd_mngr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_BAD  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  function automatic int tmo_width(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc + 1);
  endfunction

  // Tables wider than 64 entries are not supported by this helper.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/wresp_outstd_mngr_if.sv
// Handshake bundle between the write-data manager, the B channel and
// the write-response manager (slave = manager side, master = environment).
interface wresp_outstd_mngr_if #(
  parameter int ID_W  = 4,
  parameter int CNT_W = 3
);
  logic             bvalid;
  logic             bready;
  logic [ID_W-1:0]  bid;
  logic             bcomp;
  logic             finish_wd;
  logic [ID_W-1:0]  finish_id;
  logic             wd_ready;
  logic             finish_wresp;
  logic [ID_W-1:0]  finish_resp_id;
  logic [CNT_W-1:0] outstd_cnt;
  logic             resp_err;
  logic [1:0]       err_code;
  logic             err_clr;

  modport slave (
    input  bvalid, bid, bcomp, finish_wd, finish_id, err_clr,
    output bready, wd_ready, finish_wresp, finish_resp_id,
           outstd_cnt, resp_err, err_code
  );

  modport master (
    output bvalid, bid, bcomp, finish_wd, finish_id, err_clr,
    input  bready, wd_ready, finish_wresp, finish_resp_id,
           outstd_cnt, resp_err, err_code
  );
endinterface

// File: rtl/wresp_id_table.sv
// Outstanding-ID table: DEPTH {valid,id} slots, lowest-free allocation,
// lowest-matching-slot release and a registered population count.
module wresp_id_table
  import wresp_outstd_mngr_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic             pop,
  input  logic [ID_W-1:0]  pop_id,
  output logic             hit,
  output logic [CNT_W-1:0] cnt
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] hit_vec;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] match_oh;
  logic [ID_W-1:0]  id_q [DEPTH];

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      hit_vec[i] = valid_q[i] && (id_q[i] == pop_id);
  end

  // Isolate the lowest clear valid bit and the lowest set hit bit;
  // a full table yields an all-zero free mask.
  assign free_oh  = ~valid_q & (valid_q + DEPTH'(1));
  assign match_oh = hit_vec & (~hit_vec + DEPTH'(1));
  assign hit      = |hit_vec;

  always_comb begin
    valid_next = valid_q;
    if (clr) begin
      valid_next = '0;
    end else begin
      if (pop)  valid_next = valid_next & ~match_oh;
      if (push) valid_next = valid_next | free_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt     <= '0;
    end else begin
      valid_q <= valid_next;
      cnt     <= CNT_W'(popcount(64'(valid_next)));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (push && !clr && free_oh[i]) id_q[i] <= push_id;
  end

endmodule

// File: rtl/wresp_outstd_mngr.sv
// Multi-outstanding write-response manager: tracks finished write IDs and
// retires them on matching B responses. Optional timeout: WRESP_TIMEOUT_EN.
module wresp_outstd_mngr
  import wresp_outstd_mngr_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  wresp_outstd_mngr_if.slave bus
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           state;
  logic [1:0]       code_q;
  logic             bready;
  logic             wd_ready;
  logic             accept;
  logic             good;
  logic             bad;
  logic             ovf;
  logic             push;
  logic             clr;
  logic             hit;
  logic             tmo_hit;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_after;

  assign bready    = (state == ST_WAIT);
  assign wd_ready  = (state != ST_ERR) && (cnt < DEPTH_C);
  assign accept    = bus.bvalid && bready;
  assign good      = accept && bus.bcomp && hit;
  assign bad       = accept && (!bus.bcomp || !hit);
  assign push      = bus.finish_wd && wd_ready;
  assign ovf       = bus.finish_wd && (state != ST_ERR) && (cnt == DEPTH_C);
  assign clr       = (state == ST_ERR) && bus.err_clr;
  assign cnt_after = cnt + CNT_W'(push) - CNT_W'(good);

  assign bus.bready         = bready;
  assign bus.wd_ready       = wd_ready;
  assign bus.finish_wresp   = good;
  assign bus.finish_resp_id = bus.bid;
  assign bus.outstd_cnt     = cnt;
  assign bus.resp_err       = (state == ST_ERR);
  assign bus.err_code       = code_q;

  wresp_id_table #(
    .ID_W  (ID_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (push),
    .push_id (bus.finish_id),
    .pop     (good),
    .pop_id  (bus.bid),
    .hit     (hit),
    .cnt     (cnt)
  );

`ifdef WRESP_TIMEOUT_EN
  localparam int TW = tmo_width(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  logic [TW-1:0] tmo_cnt;

  // Counts idle WAIT cycles; any accepted response restarts the window.
  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT || accept) tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (state == ST_WAIT) && !accept && (tmo_cnt == TMO_LAST);
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TMO_CYC;
  assign tmo_hit    = 1'b0;
`endif

  // Response errors outrank overflow, which outranks timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      code_q <= ERR_NONE;
    end else begin
      case (state)
        ST_ERR: begin
          if (bus.err_clr) begin
            state  <= ST_IDLE;
            code_q <= ERR_NONE;
          end
        end
        default: begin
          if (bad) begin
            state  <= ST_ERR;
            code_q <= ERR_BAD;
          end else if (ovf) begin
            state  <= ST_ERR;
            code_q <= ERR_OVF;
          end else if (tmo_hit) begin
            state  <= ST_ERR;
            code_q <= ERR_TMO;
          end else begin
            state <= (cnt_after == '0) ? ST_IDLE : ST_WAIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wresp_outstd_mngr.sv
// Bench for wresp_outstd_mngr: hand-derived vector table, timeout corner
// cases when WRESP_TIMEOUT_EN is defined, then random traffic vs a queue model.
module tb_wresp_outstd_mngr;

  localparam int ID_W    = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;
  localparam int TMO_CYC = 8;

  typedef struct {
    logic       fwd;
    logic [3:0] fid;
    logic       bv;
    logic [3:0] bid;
    logic       bc;
    logic       clr;
    logic       rst;
  } in_t;

  typedef struct {
    logic       br;
    logic       wdr;
    logic       fw;
    logic [3:0] rid;
    logic [2:0] cnt;
    logic       err;
    logic [1:0] code;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wresp_outstd_mngr_if #(.ID_W(ID_W), .CNT_W(CNT_W)) bus();

  wresp_outstd_mngr #(
    .ID_W    (ID_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: a multiset of outstanding IDs plus an error latch.
  logic [3:0] m_q[$];
  bit         m_err;
  logic [1:0] m_code;
  int         m_wait;

  function automatic in_t mkIn(input int fwd, input int fid, input int bv, input int bid,
                               input int bc, input int clr, input int r);
    in_t s;
    s.fwd = fwd[0]; s.fid = fid[3:0]; s.bv = bv[0]; s.bid = bid[3:0];
    s.bc = bc[0]; s.clr = clr[0]; s.rst = r[0];
    return s;
  endfunction

  function automatic exp_t mkExp(input int br, input int wdr, input int fw, input int rid,
                                 input int cnt, input int err, input int code);
    exp_t e;
    e.br = br[0]; e.wdr = wdr[0]; e.fw = fw[0]; e.rid = rid[3:0];
    e.cnt = cnt[2:0]; e.err = err[0]; e.code = code[1:0];
    return e;
  endfunction

  function automatic vec_t row(input int fwd, input int fid, input int bv, input int bid,
                               input int bc, input int clr, input int r,
                               input int br, input int wdr, input int fw, input int rid,
                               input int cnt, input int err, input int code);
    vec_t v;
    v.i = mkIn(fwd, fid, bv, bid, bc, clr, r);
    v.e = mkExp(br, wdr, fw, rid, cnt, err, code);
    return v;
  endfunction

  function automatic int findId(input logic [3:0] id);
    for (int k = 0; k < m_q.size(); k++) if (m_q[k] == id) return k;
    return -1;
  endfunction

  function automatic exp_t modelExpect(input in_t s);
    exp_t e;
    bit   accept;
    e.br   = !m_err && (m_q.size() > 0);
    e.wdr  = !m_err && (m_q.size() < DEPTH);
    accept = s.bv && e.br;
    e.fw   = accept && s.bc && (findId(s.bid) >= 0);
    e.rid  = s.bid;
    e.cnt  = 3'(m_q.size());
    e.err  = m_err;
    e.code = m_code;
    return e;
  endfunction

  task automatic modelAdvance(input in_t s);
    int  size0;
    int  idx;
    bit  accept, bad, ovf, tmo, good;
    size0 = m_q.size();
    if (s.rst) begin
      m_q.delete(); m_err = 0; m_code = 2'b00; m_wait = 0;
    end else if (m_err) begin
      if (s.clr) begin
        m_q.delete(); m_err = 0; m_code = 2'b00;
      end
      m_wait = 0;
    end else begin
      accept = s.bv && (size0 > 0);
      idx    = findId(s.bid);
      good   = accept && s.bc && (idx >= 0);
      bad    = accept && !good;
      ovf    = s.fwd && (size0 == DEPTH);
      tmo    = 0;
`ifdef WRESP_TIMEOUT_EN
      tmo    = (size0 > 0) && !accept && (m_wait == TMO_CYC - 1);
`endif
      if (good) m_q.delete(idx);
      if (s.fwd && size0 < DEPTH) m_q.push_back(s.fid);
      if (bad)      begin m_err = 1; m_code = 2'b01; end
      else if (ovf) begin m_err = 1; m_code = 2'b10; end
      else if (tmo) begin m_err = 1; m_code = 2'b11; end
      m_wait = (size0 > 0 && !accept && !m_err) ? m_wait + 1 : 0;
    end
  endtask

  task automatic applyStimulus(input in_t s);
    bus.finish_wd = s.fwd;
    bus.finish_id = s.fid;
    bus.bvalid    = s.bv;
    bus.bid       = s.bid;
    bus.bcomp     = s.bc;
    bus.err_clr   = s.clr;
    rst           = s.rst;
  endtask

  task automatic cmpField(input string tag, input string field,
                          input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s %s got=%0h exp=%0h", tag, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    cmpField(tag, "bready",     32'(bus.bready),       32'(e.br));
    cmpField(tag, "wd_ready",   32'(bus.wd_ready),     32'(e.wdr));
    cmpField(tag, "finish_wresp", 32'(bus.finish_wresp), 32'(e.fw));
    if (e.fw) cmpField(tag, "finish_resp_id", 32'(bus.finish_resp_id), 32'(e.rid));
    cmpField(tag, "outstd_cnt", 32'(bus.outstd_cnt),   32'(e.cnt));
    cmpField(tag, "resp_err",   32'(bus.resp_err),     32'(e.err));
    cmpField(tag, "err_code",   32'(bus.err_code),     32'(e.code));
  endtask

  // One clock: drive just after the edge, compare mid-cycle, then advance.
  task automatic runCycle(input in_t s, input exp_t e, input bit use_model, input string tag);
    exp_t want;
    applyStimulus(s);
    #4;
    want = use_model ? modelExpect(s) : e;
    checkOutput(tag, want);
    modelAdvance(s);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  in_t  idle_in;
  in_t  r;
  exp_t dummy;

  initial begin
    idle_in = mkIn(0, 0, 0, 0, 0, 0, 0);
    dummy   = mkExp(0, 0, 0, 0, 0, 0, 0);
    m_err = 0; m_code = 2'b00; m_wait = 0;

    //            fwd fid bv bid bc clr rst | br wdr fw rid cnt err code
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 3, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 5, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(row(1, 3, 0, 0, 0, 0, 0,   1, 1, 0, 0, 2, 0, 0));
    tbl.push_back(row(0, 0, 1, 3, 1, 0, 0,   1, 1, 1, 3, 3, 0, 0));
    tbl.push_back(row(0, 0, 1, 5, 1, 0, 0,   1, 1, 1, 5, 2, 0, 0));
    tbl.push_back(row(0, 0, 1, 3, 1, 0, 0,   1, 1, 1, 3, 1, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 2, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(row(0, 0, 1, 2, 1, 0, 0,   1, 1, 1, 2, 2, 0, 0));
    tbl.push_back(row(0, 0, 1, 1, 1, 0, 0,   1, 1, 1, 1, 1, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 2, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(row(1, 3, 0, 0, 0, 0, 0,   1, 1, 0, 0, 2, 0, 0));
    tbl.push_back(row(1, 4, 0, 0, 0, 0, 0,   1, 1, 0, 0, 3, 0, 0));
    tbl.push_back(row(1, 5, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4, 1, 2));
    tbl.push_back(row(1, 6, 0, 0, 0, 1, 0,   0, 0, 0, 0, 4, 1, 2));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 7, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 1, 4, 1, 0, 0,   1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(row(1, 7, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 1, 7, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(row(1, 6, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 8, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(row(1, 9, 1, 6, 1, 0, 0,   1, 1, 1, 6, 2, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 2, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 2, 0, 0));
    tbl.push_back(row(1, 9, 1, 9, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(row(0, 0, 1, 9, 1, 0, 0,   1, 1, 1, 9, 1, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 2, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(row(1, 3, 0, 0, 0, 0, 0,   1, 1, 0, 0, 2, 0, 0));
    tbl.push_back(row(1, 4, 0, 0, 0, 0, 0,   1, 1, 0, 0, 3, 0, 0));
    tbl.push_back(row(1, 5, 1, 15, 1, 0, 0,  1, 0, 0, 0, 4, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4, 1, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 4, 1, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 2, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(row(1, 3, 0, 0, 0, 0, 0,   1, 1, 0, 0, 2, 0, 0));
    tbl.push_back(row(1, 4, 0, 0, 0, 0, 0,   1, 1, 0, 0, 3, 0, 0));
    tbl.push_back(row(1, 5, 1, 1, 1, 0, 0,   1, 0, 1, 1, 4, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 1, 2));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 3, 1, 2));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0));

    applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 1));
    repeat (2) @(posedge clk);
    #1;
    modelAdvance(mkIn(0, 0, 0, 0, 0, 0, 1));

    for (int n = 0; n < tbl.size(); n++)
      runCycle(tbl[n].i, tbl[n].e, 1'b0, $sformatf("vec%0d", n));

`ifdef WRESP_TIMEOUT_EN
    runCycle(mkIn(1, 2, 0, 0, 0, 0, 0), mkExp(0, 1, 0, 0, 0, 0, 0), 1'b0, "tmo_push");
    for (int k = 1; k <= TMO_CYC; k++)
      runCycle(idle_in, mkExp(1, 1, 0, 0, 1, 0, 0), 1'b0, $sformatf("tmo_wait%0d", k));
    runCycle(idle_in, mkExp(0, 0, 0, 0, 1, 1, 3), 1'b0, "tmo_err");
    runCycle(mkIn(0, 0, 0, 0, 0, 1, 0), mkExp(0, 0, 0, 0, 1, 1, 3), 1'b0, "tmo_clr");
    runCycle(mkIn(1, 2, 0, 0, 0, 0, 0), mkExp(0, 1, 0, 0, 0, 0, 0), 1'b0, "edge_push");
    for (int k = 1; k < TMO_CYC; k++)
      runCycle(idle_in, mkExp(1, 1, 0, 0, 1, 0, 0), 1'b0, $sformatf("edge_wait%0d", k));
    runCycle(mkIn(0, 0, 1, 2, 1, 0, 0), mkExp(1, 1, 1, 2, 1, 0, 0), 1'b0, "edge_resp");
    runCycle(idle_in, mkExp(0, 1, 0, 0, 0, 0, 0), 1'b0, "edge_after");
    runCycle(mkIn(1, 3, 0, 0, 0, 0, 0), mkExp(0, 1, 0, 0, 0, 0, 0), 1'b0, "rstw_push");
    for (int k = 1; k <= 3; k++)
      runCycle(idle_in, mkExp(1, 1, 0, 0, 1, 0, 0), 1'b0, $sformatf("rstw_wait%0d", k));
    runCycle(mkIn(0, 0, 0, 0, 0, 0, 1), mkExp(1, 1, 0, 0, 1, 0, 0), 1'b0, "rstw_rst");
    for (int k = 0; k < TMO_CYC + 2; k++)
      runCycle(idle_in, mkExp(0, 1, 0, 0, 0, 0, 0), 1'b0, $sformatf("rstw_idle%0d", k));
`endif

    for (int n = 0; n < 3000; n++) begin
      r.rst = ($urandom_range(99) < 1);
      r.fwd = ($urandom_range(99) < 40);
      r.fid = 4'($urandom_range(3));
      r.bv  = ($urandom_range(99) < 50);
      if (m_q.size() > 0 && $urandom_range(99) < 85)
        r.bid = m_q[$urandom_range(m_q.size() - 1)];
      else
        r.bid = 4'($urandom_range(15));
      r.bc  = ($urandom_range(99) < 95);
      r.clr = ($urandom_range(99) < 25);
      runCycle(r, dummy, 1'b1, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
